ps2_keyboard_decoder: RTL and testbench

PS2_KEYBOARD_DECODER -- requirements
Module: ps2_keyboard_decoder

---
 rtl/ps2_keyboard_decoder.sv | 244 ++++++++++++++++++++++++
 tb/tb_ps2_keyboard_decoder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines and frames 11-bit packets.
// It decodes WASD/space/Z/arrow make codes into a 3-bit operation handed off to a consumer.
module ps2_keyboard_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  input  logic       keyboard_read_fin,
  output logic       keyboard_ready,
  output logic [2:0] keyboard_data,
  output logic       frame_error,
  output logic       key_dropped
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] OP_W     = 3'b000;
  localparam logic [2:0] OP_A     = 3'b001;
  localparam logic [2:0] OP_S     = 3'b010;
  localparam logic [2:0] OP_D     = 3'b011;
  localparam logic [2:0] OP_SPACE = 3'b100;
  localparam logic [2:0] OP_Z     = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and falling-edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   ps2_fall;
  logic                   bit_in;

  // NOTE: sequential state is always written with non-blocking (<=) so every
  // flop samples the values from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync[0]  <= ps2_clock;
      data_sync[0] <= ps2_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync[i]  <= clk_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign ps2_fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in   = data_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  rx_state_t         state, state_d;
  logic [3:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic              parity_bit;
  logic              stop_bit;
  logic [TW-1:0]     timeout_cnt;

  logic              start_rx;
  logic              shift_en;
  logic              timeout_hit;
  logic              byte_valid;
  logic              bad_frame;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    start_rx    = 1'b0;
    shift_en    = 1'b0;
    timeout_hit = 1'b0;
    byte_valid  = 1'b0;
    bad_frame   = 1'b0;
    case (state)
      IDLE: begin
        if (ps2_fall && !bit_in) begin
          state_d  = RECV;
          start_rx = 1'b1;
        end
      end
      RECV: begin
        if (ps2_fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'd9) state_d = CHECK;
        end else if (timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = IDLE;
          timeout_hit = 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        // Odd parity over data+parity, and the stop bit must be high.
        if ((^{shift_reg, parity_bit}) && stop_bit) byte_valid = 1'b1;
        else                                         bad_frame  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
      stop_bit    <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      state <= state_d;
      if (start_rx || timeout_hit) begin
        bit_cnt     <= '0;
        shift_reg   <= '0;
        timeout_cnt <= '0;
      end else if (shift_en) begin
        timeout_cnt <= '0;
        bit_cnt     <= bit_cnt + 4'd1;
        if (bit_cnt < 4'd8)       shift_reg  <= {bit_in, shift_reg[7:1]};
        else if (bit_cnt == 4'd8) parity_bit <= bit_in;
        else                      stop_bit   <= bit_in;
      end else if (state == RECV) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix flags and scan-code decode
  // ---------------------------------------------------------------------------
  logic       ext_flag;
  logic       brk_flag;
  logic       is_prefix;
  logic       key_hit;
  logic [2:0] key_op;

  assign is_prefix = (shift_reg == 8'hE0) || (shift_reg == 8'hF0);

  always_comb begin
    key_hit = 1'b0;
    key_op  = OP_W;
    if (byte_valid && !is_prefix && !brk_flag) begin
      if (!ext_flag) begin
        case (shift_reg)
          8'h1D:   begin key_hit = 1'b1; key_op = OP_W;     end
          8'h1C:   begin key_hit = 1'b1; key_op = OP_A;     end
          8'h1B:   begin key_hit = 1'b1; key_op = OP_S;     end
          8'h23:   begin key_hit = 1'b1; key_op = OP_D;     end
          8'h29:   begin key_hit = 1'b1; key_op = OP_SPACE; end
          8'h1A:   begin key_hit = 1'b1; key_op = OP_Z;     end
          default: key_hit = 1'b0;
        endcase
      end else begin
        case (shift_reg)
          8'h75:   begin key_hit = 1'b1; key_op = OP_W; end
          8'h6B:   begin key_hit = 1'b1; key_op = OP_A; end
          8'h72:   begin key_hit = 1'b1; key_op = OP_S; end
          8'h74:   begin key_hit = 1'b1; key_op = OP_D; end
          default: key_hit = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (byte_valid) begin
      if (shift_reg == 8'hE0)      ext_flag <= 1'b1;
      else if (shift_reg == 8'hF0) brk_flag <= 1'b1;
      else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Consumer handshake with one-entry skid register
  // ---------------------------------------------------------------------------
  logic       skid_valid;
  logic [2:0] skid_op;
  logic       skid_pop;
  logic       skid_push;
  logic       load_direct;
  logic       drop;

  always_comb begin
    skid_pop    = skid_valid && !keyboard_read_fin && !keyboard_ready;
    load_direct = 1'b0;
    skid_push   = 1'b0;
    drop        = 1'b0;
    if (key_hit) begin
      if (keyboard_ready && !keyboard_read_fin)                     drop        = 1'b1;
      else if (!keyboard_read_fin && !keyboard_ready && !skid_valid) load_direct = 1'b1;
      else if (!skid_valid || skid_pop)                              skid_push   = 1'b1;
      else                                                           drop        = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      keyboard_ready <= 1'b0;
      keyboard_data  <= 3'b000;
      skid_valid     <= 1'b0;
      frame_error    <= 1'b0;
      key_dropped    <= 1'b0;
    end else begin
      frame_error <= bad_frame | timeout_hit;
      key_dropped <= drop;
      if (load_direct) begin
        keyboard_ready <= 1'b1;
        keyboard_data  <= key_op;
      end else if (skid_pop) begin
        keyboard_ready <= 1'b1;
        keyboard_data  <= skid_op;
      end else if (keyboard_read_fin) begin
        keyboard_ready <= 1'b0;
      end
      if (skid_push)     skid_valid <= 1'b1;
      else if (skid_pop) skid_valid <= 1'b0;
    end
  end

  // NOTE: the skid payload carries no reset; skid_valid alone decides whether
  // it is ever used, so its power-up contents are irrelevant.
  always_ff @(posedge clock) begin
    if (skid_push) skid_op <= key_op;
  end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Self-checking bench for ps2_keyboard_decoder: directed PS/2 frames, a
// transaction-level model of the key hand-off, and per-cycle output comparison.
module tb_ps2_keyboard_decoder;

  localparam int TIMEOUT = 50;
  localparam int SYNC    = 2;
  localparam int LAT     = SYNC + 2;   // stop-bit drive to visible outputs

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_clock;
  logic       ps2_data;
  logic       keyboard_read_fin;
  logic       keyboard_ready;
  logic [2:0] keyboard_data;
  logic       frame_error;
  logic       key_dropped;

  ps2_keyboard_decoder #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .ps2_clock        (ps2_clock),
    .ps2_data         (ps2_data),
    .keyboard_read_fin(keyboard_read_fin),
    .keyboard_ready   (keyboard_ready),
    .keyboard_data    (keyboard_data),
    .frame_error      (frame_error),
    .key_dropped      (key_dropped)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    else
      passed++;
  endtask

  // ---------------------------------------------------------------------------
  // Model: received frames become events at a known cycle; the model applies
  // prefix rules, the scan-code table and the consumer rules to them.
  // ---------------------------------------------------------------------------
  typedef struct {
    int         at;
    bit         ok;
    logic [7:0] b;
  } rx_ev_t;

  rx_ev_t     evq[$];
  rx_ev_t     ev_m;
  int         cyc = 0;
  bit         m_ext, m_brk, m_slot, m_wait_v, m_fe, m_kd;
  logic [2:0] m_data, m_wait, op_m;
  bit         have_m, prev_slot_m, rf_m;
  bit         chk_en = 1'b0;
  int         fe_seen = 0, kd_seen = 0, fe_win = 0;
  int         dc_lo = -1, dc_hi = -2;

  function automatic bit key_of(input bit ext, input logic [7:0] b, output logic [2:0] op);
    key_of = 1'b1;
    op     = 3'b000;
    case ({ext, b})
      9'h01D: op = 3'd0;
      9'h01C: op = 3'd1;
      9'h01B: op = 3'd2;
      9'h023: op = 3'd3;
      9'h029: op = 3'd4;
      9'h01A: op = 3'd5;
      9'h175: op = 3'd0;
      9'h16B: op = 3'd1;
      9'h172: op = 3'd2;
      9'h174: op = 3'd3;
      default: key_of = 1'b0;
    endcase
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
    m_fe = 1'b0;
    m_kd = 1'b0;
    if (reset) begin
      m_ext = 0; m_brk = 0; m_slot = 0; m_wait_v = 0; m_data = 3'b000;
      evq.delete();
    end else begin
      rf_m   = keyboard_read_fin;
      have_m = 1'b0;
      if (evq.size() > 0 && evq[0].at == cyc) begin
        ev_m = evq.pop_front();
        if (!ev_m.ok)            m_fe  = 1'b1;
        else if (ev_m.b == 8'hE0) m_ext = 1'b1;
        else if (ev_m.b == 8'hF0) m_brk = 1'b1;
        else begin
          if (!m_brk) have_m = key_of(m_ext, ev_m.b, op_m);
          m_ext = 1'b0;
          m_brk = 1'b0;
        end
      end
      prev_slot_m = m_slot;
      if (rf_m) m_slot = 1'b0;
      if (!rf_m && !m_slot && m_wait_v) begin
        m_slot = 1'b1; m_data = m_wait; m_wait_v = 1'b0;
      end
      if (have_m) begin
        if (prev_slot_m && !rf_m)  m_kd = 1'b1;
        else if (!rf_m && !m_slot) begin m_slot = 1'b1; m_data = op_m; end
        else if (!m_wait_v)        begin m_wait_v = 1'b1; m_wait = op_m; end
        else                       m_kd = 1'b1;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clock);
    if (frame_error === 1'b1) fe_seen++;
    if (key_dropped === 1'b1) kd_seen++;
    if (chk_en) begin
      check("ready", 32'(keyboard_ready), 32'(m_slot));
      check("data", 32'(keyboard_data), 32'(m_data));
      check("key_dropped", 32'(key_dropped), 32'(m_kd));
      if (cyc >= dc_lo && cyc <= dc_hi) begin
        if (frame_error === 1'b1) fe_win++;
      end else begin
        check("frame_error", 32'(frame_error), 32'(m_fe));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Sends the first nbits of a frame; a complete frame is announced to the model.
  task automatic send_bits(input logic [7:0] b, input bit par_good, input bit stop,
                           input int nbits, output int last_fall);
    logic [10:0] bits;
    bit          p;
    rx_ev_t      ev;
    p = ~^b;
    if (!par_good) p = ~p;
    bits = {stop, p, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      ps2_data = bits[k];
      wait_cycles(3);
      ps2_clock = 1'b0;
      last_fall = cyc;
      if (k == 10) begin
        ev.at = cyc + LAT;
        ev.ok = (((^b) ^ p) == 1'b1) && stop;
        ev.b  = b;
        evq.push_back(ev);
      end
      wait_cycles(6);
      ps2_clock = 1'b1;
      wait_cycles(3);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b);
    int fc;
    send_bits(b, 1'b1, 1'b1, 11, fc);
    wait_cycles(2);
  endtask

  task automatic ack();
    keyboard_read_fin = 1'b1;
    wait_cycles(1);
    keyboard_read_fin = 1'b0;
    wait_cycles(1);
  endtask

  logic [7:0] arrow_code [3] = '{8'h75, 8'h72, 8'h74};
  logic [2:0] arrow_op   [3] = '{3'b000, 3'b010, 3'b011};

  initial begin
    int fc, fe0, kd0;
    reset = 1'b1;
    ps2_clock = 1'b1;
    ps2_data = 1'b1;
    keyboard_read_fin = 1'b0;
    wait_cycles(1);
    chk_en = 1'b1;
    wait_cycles(2);
    check("reset_ready", 32'(keyboard_ready), 32'd0);
    check("reset_data", 32'(keyboard_data), 32'd0);
    reset = 1'b0;
    wait_cycles(5);

    // 1D with good parity -> W; one-cycle acknowledge clears ready.
    send_frame(8'h1D);
    check("w_ready", 32'(keyboard_ready), 32'd1);
    check("w_data", 32'(keyboard_data), 32'd0);
    keyboard_read_fin = 1'b1;
    wait_cycles(1);
    keyboard_read_fin = 1'b0;
    check("w_ack_clears", 32'(keyboard_ready), 32'd0);
    wait_cycles(2);

    // Typematic repeat of the same make code is a new operation.
    send_frame(8'h1D);
    check("repeat_ready", 32'(keyboard_ready), 32'd1);
    ack();

    // Arrow left, then its release produces nothing.
    fe0 = fe_seen;
    send_frame(8'hE0);
    send_frame(8'h6B);
    check("left_data", 32'(keyboard_data), 32'd1);
    check("left_ready", 32'(keyboard_ready), 32'd1);
    ack();
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h6B);
    check("release_no_ready", 32'(keyboard_ready), 32'd0);
    check("release_no_err", 32'(fe_seen - fe0), 32'd0);

    for (int i = 0; i < 3; i++) begin
      send_frame(8'hE0);
      send_frame(arrow_code[i]);
      check("arrow_data", 32'(keyboard_data), 32'(arrow_op[i]));
      ack();
    end

    // Wrong parity on 29 -> one error pulse, no key; then 1A -> Z.
    fe0 = fe_seen;
    send_bits(8'h29, 1'b0, 1'b1, 11, fc);
    wait_cycles(3);
    check("parity_err_pulses", 32'(fe_seen - fe0), 32'd1);
    check("parity_no_ready", 32'(keyboard_ready), 32'd0);
    send_frame(8'h1A);
    check("z_data", 32'(keyboard_data), 32'd5);
    ack();

    // Five bits then silence -> timeout error; next frame 23 -> D.
    send_bits(8'h23, 1'b1, 1'b1, 5, fc);
    dc_lo = fc + SYNC + 1 + TIMEOUT - 3;
    dc_hi = fc + SYNC + 1 + TIMEOUT + 3;
    wait_cycles(TIMEOUT + 20);
    check("timeout_pulse", 32'(fe_win), 32'd1);
    send_frame(8'h23);
    check("d_after_timeout", 32'(keyboard_data), 32'd3);
    ack();

    // Unacknowledged A, then S and SPACE both dropped.
    kd0 = kd_seen;
    send_frame(8'h1C);
    send_frame(8'h1B);
    send_frame(8'h29);
    check("held_data", 32'(keyboard_data), 32'd1);
    check("dropped_twice", 32'(kd_seen - kd0), 32'd2);
    ack();

    // Acknowledge held high while S arrives -> S parked, shown once released.
    send_frame(8'h1C);
    keyboard_read_fin = 1'b1;
    send_frame(8'h1B);
    check("skid_not_shown", 32'(keyboard_ready), 32'd0);
    keyboard_read_fin = 1'b0;
    wait_cycles(1);
    check("skid_ready", 32'(keyboard_ready), 32'd1);
    check("skid_data", 32'(keyboard_data), 32'd2);
    ack();

    // Reset in the middle of a frame, with a key pending.
    send_frame(8'h29);
    send_bits(8'h1D, 1'b1, 1'b1, 6, fc);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    check("midreset_ready", 32'(keyboard_ready), 32'd0);
    check("midreset_data", 32'(keyboard_data), 32'd0);
    check("midreset_err", 32'(frame_error), 32'd0);
    wait_cycles(5);
    send_frame(8'h1D);
    check("post_reset_ready", 32'(keyboard_ready), 32'd1);
    check("post_reset_data", 32'(keyboard_data), 32'd0);
    ack();
    wait_cycles(TIMEOUT + 10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
